// File: rtl/panel_ops.sv
// Front-panel operator functions: load address, extended address,
// examine/deposit over a req/ack memory port, and stretched CPU clear.
`timescale 1ns/1ps
module panel_ops #(
  parameter int ACK_TIMEOUT  = 15,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        cleard,
  input  logic        extd_addrd,
  input  logic        addr_loadd,
  input  logic        depd,
  input  logic        examd,
  input  logic [11:0] sr,
  input  logic [11:0] mem_rdata,
  input  logic        mem_ack,
  output logic [14:0] mem_addr,
  output logic [11:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [11:0] pc,
  output logic [2:0]  ifr,
  output logic [2:0]  dfr,
  output logic [11:0] ma,
  output logic [11:0] md,
  output logic        busy,
  output logic        cpu_clear,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE, RD, WR, CLR
  } state_t;

  localparam logic [7:0] TO_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] CLR_LAST = 8'(CLEAR_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;

  logic go_clr;
  logic go_ext;
  logic go_ld;
  logic go_dep;
  logic go_exam;
  logic take;

  // Priority-resolve the pulses into a one-hot select.
  always_comb begin
    take    = (state == IDLE) && !run;
    go_clr  = take && cleard;
    go_ext  = take && !cleard && extd_addrd;
    go_ld   = take && !cleard && !extd_addrd
              && addr_loadd;
    go_dep  = take && !cleard && !extd_addrd
              && !addr_loadd && depd;
    go_exam = take && !cleard && !extd_addrd
              && !addr_loadd && !depd && examd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      pc        <= '0;
      ifr       <= '0;
      dfr       <= '0;
      ma        <= '0;
      md        <= '0;
      busy      <= 1'b0;
      cpu_clear <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            go_clr: begin
              cpu_clear <= 1'b1;
              cnt       <= '0;
              busy      <= 1'b1;
              state     <= CLR;
            end
            go_ext: begin
              ifr <= sr[5:3];
              dfr <= sr[2:0];
            end
            go_ld: begin
              pc <= sr;
              ma <= sr;
            end
            go_dep: begin
              mem_addr  <= {ifr, pc};
              mem_wdata <= sr;
              mem_we    <= 1'b1;
              cnt       <= '0;
              mem_err   <= 1'b0;
              busy      <= 1'b1;
              state     <= WR;
            end
            go_exam: begin
              mem_addr <= {ifr, pc};
              mem_re   <= 1'b1;
              cnt      <= '0;
              mem_err  <= 1'b0;
              busy     <= 1'b1;
              state    <= RD;
            end
            default: ;
          endcase
        end
        RD, WR: begin
          if (mem_ack) begin
            md     <= (state == RD) ? mem_rdata
                                    : mem_wdata;
            ma     <= pc;
            pc     <= pc + 12'd1;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (cnt == TO_LAST) begin
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            mem_err <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CLR: begin
          if (cnt == CLR_LAST) begin
            cpu_clear <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_panel_ops.sv
// Scoreboard bench for panel_ops: stimulus queues expected requests,
// completions and clear widths; monitors pop and compare.
`timescale 1ns/1ps
module tb_panel_ops;

  logic        clk = 0;
  logic        reset = 0;
  logic        run = 0;
  logic        cleard = 0;
  logic        extd_addrd = 0;
  logic        addr_loadd = 0;
  logic        depd = 0;
  logic        examd = 0;
  logic [11:0] sr = 0;
  logic [11:0] mem_rdata = 0;
  logic        mem_ack = 0;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [11:0] pc;
  logic [2:0]  ifr;
  logic [2:0]  dfr;
  logic [11:0] ma;
  logic [11:0] md;
  logic        busy;
  logic        cpu_clear;
  logic        mem_err;

  panel_ops #(.ACK_TIMEOUT(15), .CLEAR_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .run(run),
    .cleard(cleard), .extd_addrd(extd_addrd),
    .addr_loadd(addr_loadd), .depd(depd), .examd(examd),
    .sr(sr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we),
    .pc(pc), .ifr(ifr), .dfr(dfr), .ma(ma), .md(md),
    .busy(busy), .cpu_clear(cpu_clear), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic [11:0] wdata;
    logic [7:0]  len;
  } req_t;

  typedef struct packed {
    logic [11:0] pc;
    logic [11:0] ma;
    logic [11:0] md;
    logic [2:0]  ifr;
    logic [2:0]  dfr;
    logic        err;
  } st_t;

  req_t req_q[$];
  st_t  st_q[$];
  int   clr_q[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // Request monitor
  logic req_prev = 0;
  int   req_len = 0;
  req_t cur;
  always @(negedge clk) begin
    req_t e;
    if (mem_re || mem_we) begin
      if (!req_prev) begin
        cur.we    = mem_we;
        cur.addr  = mem_addr;
        cur.wdata = mem_wdata;
        req_len   = 0;
        check("req_exclusive", {mem_re, mem_we}, {~mem_we, mem_we});
      end else begin
        check("req_stable", {mem_we, mem_addr, mem_wdata},
              {cur.we, cur.addr, cur.wdata});
      end
      req_len++;
      req_prev = 1;
    end else if (req_prev) begin
      req_prev = 0;
      check("req_expected", req_q.size() != 0, 1);
      if (req_q.size() != 0) begin
        e = req_q.pop_front();
        check("req_type", cur.we, e.we);
        check("req_addr", cur.addr, e.addr);
        if (e.we) check("req_wdata", cur.wdata, e.wdata);
        check("req_len", req_len, e.len);
      end
    end
  end

  // Completion monitor: state after busy falls
  logic busy_prev = 0;
  always @(negedge clk) begin
    st_t e;
    if (busy_prev && !busy) begin
      check("done_expected", st_q.size() != 0, 1);
      if (st_q.size() != 0) begin
        e = st_q.pop_front();
        check("done_pc", pc, e.pc);
        check("done_ma", ma, e.ma);
        check("done_md", md, e.md);
        check("done_ifr", ifr, e.ifr);
        check("done_dfr", dfr, e.dfr);
        check("done_err", mem_err, e.err);
      end
    end
    busy_prev = busy;
  end

  // Clear width monitor
  logic clr_prev = 0;
  int   clr_len = 0;
  always @(negedge clk) begin
    int e;
    if (cpu_clear) begin
      if (!clr_prev) clr_len = 0;
      clr_len++;
      clr_prev = 1;
    end else if (clr_prev) begin
      clr_prev = 0;
      check("clr_expected", clr_q.size() != 0, 1);
      if (clr_q.size() != 0) begin
        e = clr_q.pop_front();
        check("clr_len", clr_len, e);
      end
    end
  end

  // m = {clr, ext, ld, dep, exam}
  task automatic pulse(input logic [4:0] m);
    @(posedge clk);
    #1 {cleard, extd_addrd, addr_loadd, depd, examd} = m;
    @(posedge clk);
    #1 {cleard, extd_addrd, addr_loadd, depd, examd} = '0;
  endtask

  task automatic ack_after(input int n);
    repeat (n - 1) @(posedge clk);
    #1 mem_ack = 1;
    @(posedge clk);
    #1 mem_ack = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [4:0] P_CLR  = 5'b10000;
  localparam logic [4:0] P_EXT  = 5'b01000;
  localparam logic [4:0] P_LD   = 5'b00100;
  localparam logic [4:0] P_DEP  = 5'b00010;
  localparam logic [4:0] P_EXAM = 5'b00001;

  initial begin
    #2;
    check("reset_outs",
          {mem_addr, mem_wdata, mem_re, mem_we, pc},
          '0);
    check("reset_regs",
          {ifr, dfr, ma, md, busy, cpu_clear, mem_err}, '0);
    @(posedge clk);
    #1 reset = 1;

    sr = 12'o0200;
    pulse(P_LD);
    check("ld_pc", pc, 12'o0200);
    check("ld_ma", ma, 12'o0200);
    check("ld_busy", busy, 0);

    sr = 12'o0025;
    pulse(P_EXT);
    check("ext_ifr", ifr, 3'd2);
    check("ext_dfr", dfr, 3'd5);

    sr = 12'o5402;
    req_q.push_back('{1'b1, 15'o20200, 12'o5402, 8'd3});
    st_q.push_back('{12'o0201, 12'o0200, 12'o5402, 3'd2, 3'd5, 1'b0});
    pulse(P_DEP);
    ack_after(3);
    idle(2);

    sr = 12'o0200;
    pulse(P_LD);
    mem_rdata = 12'o5402;
    req_q.push_back('{1'b0, 15'o20200, 12'o0, 8'd2});
    st_q.push_back('{12'o0201, 12'o0200, 12'o5402, 3'd2, 3'd5, 1'b0});
    pulse(P_EXAM);
    ack_after(2);
    idle(2);

    sr = 12'o7777;
    pulse(P_LD);
    mem_rdata = 12'o1234;
    req_q.push_back('{1'b0, 15'o27777, 12'o0, 8'd1});
    st_q.push_back('{12'o0000, 12'o7777, 12'o1234, 3'd2, 3'd5, 1'b0});
    pulse(P_EXAM);
    ack_after(1);
    idle(2);
    check("wrap_pc", pc, 12'o0000);
    check("wrap_ifr", ifr, 3'd2);

    req_q.push_back('{1'b0, 15'o20000, 12'o0, 8'd15});
    st_q.push_back('{12'o0000, 12'o7777, 12'o1234, 3'd2, 3'd5, 1'b1});
    pulse(P_EXAM);
    idle(20);
    check("timeout_err", mem_err, 1);

    sr = 12'o0011;
    req_q.push_back('{1'b1, 15'o20000, 12'o0011, 8'd4});
    st_q.push_back('{12'o0001, 12'o0000, 12'o0011, 3'd2, 3'd5, 1'b0});
    pulse(P_DEP);
    ack_after(4);
    idle(2);
    check("dep_clears_err", mem_err, 0);

    clr_q.push_back(4);
    st_q.push_back('{12'o0001, 12'o0000, 12'o0011, 3'd2, 3'd5, 1'b0});
    pulse(P_CLR | P_DEP);
    check("clr_busy", busy, 1);
    pulse(P_DEP);
    idle(8);
    check("clr_no_req", {mem_re, mem_we, busy, cpu_clear}, '0);

    run = 1;
    pulse(P_EXAM);
    idle(3);
    check("run_no_req", {mem_re, busy}, '0);
    run = 0;

    req_q.push_back('{1'b0, 15'o20001, 12'o0, 8'd1});
    st_q.push_back('{12'o0, 12'o0, 12'o0, 3'd0, 3'd0, 1'b0});
    pulse(P_EXAM);
    @(posedge clk);
    #2 reset = 0;
    #1;
    check("rst_mid_req", {mem_re, mem_we, busy}, '0);
    check("rst_mid_outs", {mem_addr, mem_wdata, pc, ma, md}, '0);
    check("rst_mid_regs", {ifr, dfr, cpu_clear, mem_err}, '0);
    idle(2);
    reset = 1;
    mem_rdata = 12'o4321;
    mem_ack = 1;
    idle(1);
    mem_ack = 0;
    idle(2);
    check("late_ack_ignored", {pc, md, busy}, '0);

    check("req_q_empty", req_q.size(), 0);
    check("st_q_empty", st_q.size(), 0);
    check("clr_q_empty", clr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/panel_ops.md
Name: panel_ops

Overview:
- Executes front-panel operator functions on the CPU's program state and memory.
- Sits directly downstream of front_panel and consumes its debounced single-cycle pulses: cleard, extd_addrd, addr_loadd, depd, examd.
- Handles Load Address, Extended Address Load, Examine and Deposit through a request/ack memory handshake.
- Generates the stretched CPU clear.
- Drives the PC/IF/DF registers and the MA/MD lamp registers.

Parameters:
- ACK_TIMEOUT, 15: maximum cycles a memory request is held without mem_ack before the operation is aborted (range 2..255).
- CLEAR_CYCLES, 4: number of cycles cpu_clear is held high after an accepted clear (range 1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  high while the CPU state machine is running; all panel operations are ignored while high.
- cleard  in  1  clear pulse, 1 cycle.
- extd_addrd  in  1  extended address load pulse, 1 cycle.
- addr_loadd  in  1  load address pulse, 1 cycle.
- depd  in  1  deposit pulse, 1 cycle.
- examd  in  1  examine pulse, 1 cycle.
- sr  in  12  switch register, bit 0 = MSB (PDP-8 numbering).
- mem_rdata  in  12  memory read data, valid when mem_ack is high.
- mem_ack  in  1  memory completion strobe, 1 cycle.
- mem_addr  out  15  {ifr, pc} captured at operation start.
- mem_wdata  out  12  write data.
- mem_re  out  1  read request.
- mem_we  out  1  write request.
- pc  out  12  program counter.
- ifr  out  3  instruction field.
- dfr  out  3  data field.
- ma  out  12  memory address lamp register.
- md  out  12  memory data lamp register.
- busy  out  1  high when not in IDLE.
- cpu_clear  out  1  stretched clear to the CPU.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset (reset=0, asynchronous): every output and internal register goes to 0, including the request lines. State returns to IDLE. An in-flight request is dropped immediately, and a mem_ack arriving after reset is ignored.
- States: IDLE, RD, WR, CLR.
- Pulses are sampled only in IDLE with run=0. A pulse arriving while busy=1 or run=1 is discarded and never queued.
- Simultaneous pulses are resolved by priority: cleard > extd_addrd > addr_loadd > depd > examd. Only the highest-priority pulse is acted on; the rest are discarded.
- addr_loadd: pc<=sr and ma<=sr at the sampling edge. State stays IDLE; no memory access.
- extd_addrd: ifr<=sr[6:8] and dfr<=sr[9:11] at the sampling edge. State stays IDLE.
- examd: at the sampling edge, mem_addr<={ifr,pc}, mem_re<=1, timeout counter cleared, mem_err<=0, state to RD.
- In RD, on an edge with mem_ack=1:
  - md<=mem_rdata, ma<=pc.
  - pc<=(pc+1) mod 4096; ifr is not incremented, so 7777 wraps to 0000 within the field.
  - mem_re<=0, state to IDLE.
- depd: at the sampling edge, mem_addr<={ifr,pc}, mem_wdata<=sr, mem_we<=1, counter cleared, mem_err<=0, state to WR.
- In WR, on an edge with mem_ack=1: md<=mem_wdata, ma<=pc, pc incremented as for examine, mem_we<=0, state to IDLE.
- mem_addr and mem_wdata are held stable for as long as the request is asserted. mem_re and mem_we are never high together.
- Timeout: if mem_ack has not been seen by the edge at which the request has been high for ACK_TIMEOUT cycles, then:
  - the request drops, mem_err<=1, state to IDLE;
  - pc, ma and md are unchanged.
  - mem_err stays set until the next accepted examd or depd.
- mem_ack seen while in IDLE or CLR is ignored.
- cleard: cpu_clear<=1 at the sampling edge, state to CLR. cpu_clear is high for exactly CLEAR_CYCLES cycles, then cpu_clear<=0 and state returns to IDLE. pc, ifr, dfr, ma and md are not modified by clear.
- busy is a registered output and is high exactly when state≠IDLE.
- Latency (edge 0 = the edge at which the pulse is sampled):
  - Request outputs are high from edge 0.
  - An ack sampled at edge N updates pc, ma and md at edge N, and busy falls at edge N.
  - Examine/deposit minimum: 1 cycle of request.
- run rising mid-operation does not abort the operation; the handshake completes normally.

Test Plan:
- Reset, then run=0, sr=0o0200, pulse addr_loadd -> pc=0o0200, ma=0o0200 one edge later; busy stays 0.
- sr=0o0025, pulse extd_addrd -> ifr=2, dfr=5.
- With ifr=2 and pc=0o0200: sr=0o5402, pulse depd, mem_ack 3 cycles later ->
  - mem_we high 3 cycles, mem_addr=0o20200, mem_wdata=0o5402;
  - afterwards pc=0o0201, ma=0o0200, md=0o5402.
- Then pulse addr_loadd with sr=0o0200, then examd with mem_rdata=0o5402 on ack -> md=0o5402, pc=0o0201.
- pc=0o7777, examd and ack -> pc=0o0000, ifr unchanged.
- examd with mem_ack never asserted (ACK_TIMEOUT=15) ->
  - mem_re high exactly 15 cycles, then mem_err=1, pc unchanged;
  - a following acked depd clears mem_err.
- cleard and depd in the same cycle -> cpu_clear high exactly 4 cycles, no memory request.
- depd during CLR -> ignored.
- run=1 with examd -> no request.
- reset asserted mid-RD -> mem_re=0 immediately, all outputs 0.
